// File: rtl/new_game_pkg.sv
// -----------------------------------------------------------------------------
// new_game_pkg
//   Shared types and constants for the new-game handshake and the object-memory
//   (OM) write path.
//   - nga_state_e : arbiter state encoding
//   - OM_ADDR_W / OM_DATA_W : OM write port geometry
//   - BOARD_WORDS : number of words in a full board load
//   - sat_inc() : saturating increment used by the load word counter
// -----------------------------------------------------------------------------
package new_game_pkg;

    localparam int OM_ADDR_W   = 7;
    localparam int OM_DATA_W   = 11;
    localparam int BOARD_WORDS = 105;
    localparam int WORD_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_GRANTED = 2'd2,
        ST_FINISH  = 2'd3
    } nga_state_e;

    // Increment by one when en is set, sticking at the all-ones value.
    function automatic logic [WORD_CNT_W-1:0] sat_inc(
        input logic [WORD_CNT_W-1:0] value,
        input logic                  en
    );
        if (en && (value != {WORD_CNT_W{1'b1}})) begin
            return value + WORD_CNT_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/om_write_mux.sv
// -----------------------------------------------------------------------------
// om_write_mux
//   2:1 selector in front of the single OM write port. Shared by every block
//   that needs to hand the port between two writers.
//   Ports:
//     i_sel                       0 = port A, 1 = port B
//     i_a_addr/i_a_data/i_a_wren  writer A
//     i_b_addr/i_b_data/i_b_wren  writer B
//     o_addr/o_data/o_wren        to the OM write port (combinational)
// -----------------------------------------------------------------------------
module om_write_mux
    import new_game_pkg::*;
#(
    parameter int ADDR_W = OM_ADDR_W,
    parameter int DATA_W = OM_DATA_W
) (
    input  logic              i_sel,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_wren,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_wren,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wren
);

    // NOTE: every output is fully assigned on both select values, so no latch can form.
    assign o_addr = i_sel ? i_b_addr : i_a_addr;
    assign o_data = i_sel ? i_b_data : i_a_data;
    // The unselected writer's enable is dropped, not queued.
    assign o_wren = i_sel ? i_b_wren : i_a_wren;

endmodule

// File: rtl/new_game_arbiter.sv
// -----------------------------------------------------------------------------
// new_game_arbiter
//   Responder side of the new-game handshake. Latches the coordinator's
//   request, waits for gameplay to leave a move, grants the OM write port to
//   the coordinator and freezes gameplay until the coordinator signals that
//   the board load is complete.
//
//   Optional feature: define NGA_TIMEOUT_EN to enable the grant watchdog
//   (TIMEOUT_CYCLES cycles from grant to new_game_ready). Without it,
//   timeout_error is constant 0 and a grant is held indefinitely.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     new_game_request           1-cycle request pulse from the coordinator
//     new_game_in_progress       registered: grant held
//     resetting                  coordinator status (debug only, no effect)
//     new_game_ready             1-cycle pulse: board load complete
//     coord_addr/data/wren       coordinator OM write port
//     game_addr/data/wren        gameplay OM write port
//     game_busy                  gameplay mid-move, grant deferred
//     game_hold                  registered: gameplay frozen (not IDLE)
//     om_addr/data/wren          to the OM write port
//     game_started               registered 1-cycle pulse: new board live
//     words_written              coordinator writes seen in the last grant
//     timeout_error              sticky watchdog flag
// -----------------------------------------------------------------------------
module new_game_arbiter
    import new_game_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_game_request,
    output logic                  new_game_in_progress,
    input  logic                  resetting,
    input  logic                  new_game_ready,
    input  logic [OM_ADDR_W-1:0]  coord_addr,
    input  logic [OM_DATA_W-1:0]  coord_data,
    input  logic                  coord_wren,
    input  logic [OM_ADDR_W-1:0]  game_addr,
    input  logic [OM_DATA_W-1:0]  game_data,
    input  logic                  game_wren,
    input  logic                  game_busy,
    output logic                  game_hold,
    output logic [OM_ADDR_W-1:0]  om_addr,
    output logic [OM_DATA_W-1:0]  om_data,
    output logic                  om_wren,
    output logic                  game_started,
    output logic [WORD_CNT_W-1:0] words_written,
    output logic                  timeout_error
);

    nga_state_e            r_state;
    logic                  r_in_progress;
    logic                  r_hold;
    logic                  r_started;
    logic                  r_timeout_error;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic [WORD_CNT_W-1:0] r_words_written;

    logic                  w_coord_sel;
    logic                  w_timeout;
    logic                  w_unused_status;

    // The coordinator keeps the port through FINISH so a write issued in the
    // same cycle as (or right after) new_game_ready still lands.
    assign w_coord_sel = (r_state == ST_GRANTED) || (r_state == ST_FINISH);

    // Debug tap only; it must not influence the handshake.
    assign w_unused_status = resetting;

    // -------------------------------------------------------------------------
    // Handshake FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every branch sees
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_in_progress   <= 1'b0;
            r_hold          <= 1'b0;
            r_started       <= 1'b0;
            r_timeout_error <= 1'b0;
            r_word_cnt      <= '0;
            r_words_written <= '0;
        end else begin
            r_started <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (new_game_request) begin
                        r_hold <= 1'b1;
                        if (!game_busy) begin
                            r_state       <= ST_GRANTED;
                            r_in_progress <= 1'b1;
                            r_word_cnt    <= '0;
                        end else begin
                            r_state <= ST_PENDING;
                        end
                    end
                end

                // Further request pulses here are absorbed: the request is
                // already latched by being in this state.
                ST_PENDING: begin
                    if (!game_busy) begin
                        r_state       <= ST_GRANTED;
                        r_in_progress <= 1'b1;
                        r_word_cnt    <= '0;
                    end
                end

                ST_GRANTED: begin
                    r_word_cnt <= sat_inc(r_word_cnt, coord_wren);
                    if (new_game_ready) begin
                        r_state         <= ST_FINISH;
                        r_in_progress   <= 1'b0;
                        r_started       <= 1'b1;
                        // Include this cycle's write so the count is complete
                        // while game_started is high.
                        r_words_written <= sat_inc(r_word_cnt, coord_wren);
                        r_timeout_error <= 1'b0;
                    end else if (w_timeout) begin
                        r_state         <= ST_IDLE;
                        r_in_progress   <= 1'b0;
                        r_hold          <= 1'b0;
                        r_timeout_error <= 1'b1;
                    end
                end

                // A request landing in the single FINISH cycle is kept by
                // going to PENDING; gameplay stays frozen across the gap.
                ST_FINISH: begin
                    if (new_game_request) begin
                        r_state <= ST_PENDING;
                        r_hold  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_hold  <= 1'b0;
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_in_progress <= 1'b0;
                    r_hold        <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Grant watchdog
    // -------------------------------------------------------------------------
`ifdef NGA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts GRANTED cycles; any other state holds it at zero so each grant
    // starts a fresh window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_GRANTED) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Fires in the last allowed GRANTED cycle; new_game_ready in that same
    // cycle still wins.
    assign w_timeout = (r_state == ST_GRANTED) &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] w_unused_tmo_cnt;

    assign w_unused_tmo_cnt = '0;
    assign w_timeout        = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // OM write port: gameplay on A, coordinator on B
    // -------------------------------------------------------------------------
    om_write_mux #(
        .ADDR_W (OM_ADDR_W),
        .DATA_W (OM_DATA_W)
    ) u_om_write_mux (
        .i_sel    (w_coord_sel),
        .i_a_addr (game_addr),
        .i_a_data (game_data),
        .i_a_wren (game_wren),
        .i_b_addr (coord_addr),
        .i_b_data (coord_data),
        .i_b_wren (coord_wren),
        .o_addr   (om_addr),
        .o_data   (om_data),
        .o_wren   (om_wren)
    );

    assign new_game_in_progress = r_in_progress;
    assign game_hold            = r_hold;
    assign game_started         = r_started;
    assign words_written        = r_words_written;
    assign timeout_error        = r_timeout_error;

endmodule

// File: tb/tb_new_game_arbiter.sv
// -----------------------------------------------------------------------------
// tb_new_game_arbiter
//   Scoreboard bench. Stimulus tasks work out, from the handshake rules, the
//   cycle at which every observable event must happen (OM writes, grant and
//   hold edges, game_started with its word count, watchdog edges, reset
//   snapshots) and queue it. A negedge monitor pops and compares whenever the
//   DUT shows the event. Build with +define+NGA_TIMEOUT_EN to add the watchdog
//   scenario (TIMEOUT_CYCLES = 16).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_new_game_arbiter;
    import new_game_pkg::*;

    localparam int TMO = 16;
`ifdef NGA_TIMEOUT_EN
    // Keep every grant shorter than the watchdog window.
    localparam int MAX_WORDS = 8;
    localparam int RST_WORDS = 10;
`else
    localparam int MAX_WORDS = 1000;
    localparam int RST_WORDS = 40;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  new_game_request;
    logic                  new_game_in_progress;
    logic                  resetting;
    logic                  new_game_ready;
    logic [OM_ADDR_W-1:0]  coord_addr;
    logic [OM_DATA_W-1:0]  coord_data;
    logic                  coord_wren;
    logic [OM_ADDR_W-1:0]  game_addr;
    logic [OM_DATA_W-1:0]  game_data;
    logic                  game_wren;
    logic                  game_busy;
    logic                  game_hold;
    logic [OM_ADDR_W-1:0]  om_addr;
    logic [OM_DATA_W-1:0]  om_data;
    logic                  om_wren;
    logic                  game_started;
    logic [WORD_CNT_W-1:0] words_written;
    logic                  timeout_error;

    new_game_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .new_game_request     (new_game_request),
        .new_game_in_progress (new_game_in_progress),
        .resetting            (resetting),
        .new_game_ready       (new_game_ready),
        .coord_addr           (coord_addr),
        .coord_data           (coord_data),
        .coord_wren           (coord_wren),
        .game_addr            (game_addr),
        .game_data            (game_data),
        .game_wren            (game_wren),
        .game_busy            (game_busy),
        .game_hold            (game_hold),
        .om_addr              (om_addr),
        .om_data              (om_data),
        .om_wren              (om_wren),
        .game_started         (game_started),
        .words_written        (words_written),
        .timeout_error        (timeout_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct { int cyc; logic [6:0] addr; logic [10:0] data; } wr_t;
    typedef struct { int cyc; logic val; } tgl_t;
    typedef struct { int cyc; logic [7:0] words; } start_t;

    wr_t    wr_q[$];
    tgl_t   nip_q[$];
    tgl_t   hold_q[$];
    tgl_t   tmo_q[$];
    start_t start_q[$];
    int     snap_q[$];

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    bit exp_tmo = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic   p_nip  = 1'b0;
    logic   p_hold = 1'b0;
    logic   p_tmo  = 1'b0;
    wr_t    m_wr;
    tgl_t   m_t;
    start_t m_s;

    always @(negedge clk) begin
        if (mon_en) begin
            if (snap_q.size() != 0 && snap_q[0] == cyc) begin
                void'(snap_q.pop_front());
                check("reset_state_outputs",
                      {new_game_in_progress, game_hold, om_addr, om_data, om_wren,
                       game_started, words_written, timeout_error}, '0);
            end

            if (om_wren !== 1'b0) begin
                if (wr_q.size() == 0) begin
                    check("om_wren_unexpected", om_wren, 1'b0);
                end else begin
                    m_wr = wr_q.pop_front();
                    check("om_write_cycle", cyc, m_wr.cyc);
                    check("om_write_addr", om_addr, m_wr.addr);
                    check("om_write_data", om_data, m_wr.data);
                end
            end

            if (new_game_in_progress !== p_nip) begin
                if (nip_q.size() == 0) begin
                    check("in_progress_unexpected_edge", new_game_in_progress, p_nip);
                end else begin
                    m_t = nip_q.pop_front();
                    check("in_progress_edge_cycle", cyc, m_t.cyc);
                    check("in_progress_edge_value", new_game_in_progress, m_t.val);
                end
                p_nip = new_game_in_progress;
            end

            if (game_hold !== p_hold) begin
                if (hold_q.size() == 0) begin
                    check("game_hold_unexpected_edge", game_hold, p_hold);
                end else begin
                    m_t = hold_q.pop_front();
                    check("game_hold_edge_cycle", cyc, m_t.cyc);
                    check("game_hold_edge_value", game_hold, m_t.val);
                end
                p_hold = game_hold;
            end

            if (timeout_error !== p_tmo) begin
                if (tmo_q.size() == 0) begin
                    check("timeout_error_unexpected_edge", timeout_error, p_tmo);
                end else begin
                    m_t = tmo_q.pop_front();
                    check("timeout_error_edge_cycle", cyc, m_t.cyc);
                    check("timeout_error_edge_value", timeout_error, m_t.val);
                end
                p_tmo = timeout_error;
            end

            if (game_started !== 1'b0) begin
                if (start_q.size() == 0) begin
                    check("game_started_unexpected", game_started, 1'b0);
                end else begin
                    m_s = start_q.pop_front();
                    check("game_started_cycle", cyc, m_s.cyc);
                    check("words_written", words_written, m_s.words);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one gameplay cycle; pass says whether the write must reach OM.
    task automatic game_cycle(input bit en, input bit pass, input logic [6:0] addr);
        wr_t e;
        game_wren = en;
        game_addr = addr;
        game_data = 11'($urandom);
        if (en && pass) begin
            e = '{cyc, game_addr, game_data};
            wr_q.push_back(e);
        end
    endtask

    // Request from IDLE; returns at the first GRANTED cycle.
    task automatic req_phase(input int busy_len, input bit game_wr, input bit extra_req, output int g);
        int   p0;
        tgl_t t;
        p0 = cyc;
        new_game_request = 1'b1;
        game_busy        = (busy_len > 0);
        game_cycle(game_wr, 1'b1, 7'd5);
        t = '{p0 + 1, 1'b1};
        hold_q.push_back(t);
        g = p0 + busy_len + 1;
        t = '{g, 1'b1};
        nip_q.push_back(t);
        step();
        while (cyc < g) begin
            game_busy        = (cyc < p0 + busy_len);
            new_game_request = extra_req && (cyc == p0 + 2);
            game_cycle(game_wr, 1'b1, 7'd5);
            step();
        end
        new_game_request = 1'b0;
        game_busy        = 1'b0;
    endtask

    // Load n words then ready. With fin_req a new request is sent in FINISH
    // and the task returns at the next GRANTED cycle.
    task automatic grant_phase(input int n_in, input bit game_wr, input bit extra_req,
                               input bit trail, input bit fin_req);
        int     g, r, n, issued, cnt;
        wr_t    e;
        tgl_t   t;
        start_t s;
        n      = (n_in > MAX_WORDS) ? MAX_WORDS : n_in;
        g      = cyc;
        issued = 0;
        cnt    = 0;
        while (issued < n) begin
`ifdef NGA_TIMEOUT_EN
            coord_wren = 1'b1;
`else
            coord_wren = ($urandom_range(0, 3) != 0);
`endif
            coord_addr = 7'(issued);
            coord_data = 11'($urandom);
            if (coord_wren) begin
                e = '{cyc, coord_addr, coord_data};
                wr_q.push_back(e);
                issued++;
                cnt++;
            end
            new_game_request = extra_req && (cyc == g + 2);
            game_cycle(game_wr, 1'b0, 7'd5);
            step();
        end

        r                = cyc;
        new_game_request = 1'b0;
        new_game_ready   = 1'b1;
        coord_wren       = trail;
        coord_addr       = 7'd104;
        coord_data       = 11'($urandom);
        if (trail) begin
            e = '{cyc, coord_addr, coord_data};
            wr_q.push_back(e);
            cnt++;
        end
        game_cycle(game_wr, 1'b0, 7'd5);
        t = '{r + 1, 1'b0};
        nip_q.push_back(t);
        s = '{r + 1, (cnt > 255) ? 8'd255 : 8'(cnt)};
        start_q.push_back(s);
        if (exp_tmo) begin
            tmo_q.push_back(t);
            exp_tmo = 1'b0;
        end
        if (!fin_req) begin
            t = '{r + 2, 1'b0};
            hold_q.push_back(t);
        end
        step();

        // FINISH cycle: trailing coordinator write still lands
        new_game_ready   = 1'b0;
        coord_wren       = trail;
        coord_addr       = 7'($urandom_range(0, 104));
        coord_data       = 11'($urandom);
        if (trail) begin
            e = '{cyc, coord_addr, coord_data};
            wr_q.push_back(e);
        end
        new_game_request = fin_req;
        game_cycle(game_wr, 1'b0, 7'd5);
        step();

        coord_wren       = 1'b0;
        new_game_request = 1'b0;
        if (fin_req) begin
            t = '{r + 3, 1'b1};
            nip_q.push_back(t);
            game_cycle(game_wr, 1'b1, 7'd5);
            step();
        end else begin
            repeat (3) begin
                game_cycle(game_wr, 1'b1, 7'($urandom_range(0, 127)));
                step();
            end
            game_wren = 1'b0;
        end
    endtask

    task automatic reset_mid_grant();
        int   g;
        wr_t  e;
        tgl_t t;
        req_phase(0, 1'b0, 1'b0, g);
        for (int i = 0; i < RST_WORDS; i++) begin
            coord_wren = 1'b1;
            coord_addr = 7'(i);
            coord_data = 11'($urandom);
            e = '{cyc, coord_addr, coord_data};
            wr_q.push_back(e);
            step();
        end
        coord_wren = 1'b0;
        coord_addr = '0;
        coord_data = '0;
        game_wren  = 1'b0;
        game_addr  = '0;
        game_data  = '0;
        reset      = 1'b1;
        t = '{cyc + 1, 1'b0};
        nip_q.push_back(t);
        hold_q.push_back(t);
        if (exp_tmo) begin
            tmo_q.push_back(t);
            exp_tmo = 1'b0;
        end
        snap_q.push_back(cyc + 1);
        step();
        step();
        reset = 1'b0;
        step();
    endtask

`ifdef NGA_TIMEOUT_EN
    task automatic timeout_run();
        int   g;
        tgl_t t;
        req_phase(0, 1'b0, 1'b0, g);
        t = '{g + TMO, 1'b0};
        nip_q.push_back(t);
        hold_q.push_back(t);
        t = '{g + TMO, 1'b1};
        tmo_q.push_back(t);
        exp_tmo = 1'b1;
        repeat (TMO + 4) step();
        // A late ready after the watchdog fired must be ignored.
        new_game_ready = 1'b1;
        step();
        new_game_ready = 1'b0;
        step();
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        int g;
        reset            = 1'b1;
        new_game_request = 1'b0;
        resetting        = 1'b0;
        new_game_ready   = 1'b0;
        coord_addr       = '0;
        coord_data       = '0;
        coord_wren       = 1'b0;
        game_addr        = '0;
        game_data        = '0;
        game_wren        = 1'b0;
        game_busy        = 1'b0;

        step();
        step();
        mon_en = 1'b1;
        snap_q.push_back(cyc);
        step();
        reset = 1'b0;
        step();

        // Gameplay owns the port while idle
        repeat (8) begin
            game_cycle(1'($urandom_range(0, 1)), 1'b1, 7'($urandom_range(0, 127)));
            step();
        end
        game_wren = 1'b0;

        // Ready while idle is ignored
        new_game_ready = 1'b1;
        step();
        new_game_ready = 1'b0;
        step();

        // Idle grant, full board
        req_phase(0, 1'b0, 1'b0, g);
        grant_phase(BOARD_WORDS, 1'b0, 1'b0, 1'b0, 1'b0);

        // Busy defer for 20 cycles, gameplay writing throughout, extra requests
        resetting = 1'b1;
        req_phase(20, 1'b1, 1'b1, g);
        grant_phase(30, 1'b1, 1'b1, 1'b0, 1'b0);
        resetting = 1'b0;

        // Trailing writes in ready and FINISH cycles
        req_phase(0, 1'b1, 1'b0, g);
        grant_phase(BOARD_WORDS - 1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Request landing in FINISH goes through PENDING to a second grant
        req_phase(0, 1'b0, 1'b0, g);
        grant_phase(6, 1'b1, 1'b0, 1'b0, 1'b1);
        grant_phase(5, 1'b1, 1'b0, 1'b1, 1'b0);

        reset_mid_grant();

        // Word counter saturation
        req_phase(0, 1'b0, 1'b0, g);
        grant_phase(300, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized loads
        for (int k = 0; k < 6; k++) begin
            bit fin;
            fin = 1'($urandom_range(0, 1));
            req_phase($urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g);
            grant_phase($urandom_range(0, 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), fin);
            if (fin) begin
                grant_phase($urandom_range(0, 10), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            repeat ($urandom_range(0, 3)) step();
        end

`ifdef NGA_TIMEOUT_EN
        timeout_run();
        req_phase(0, 1'b0, 1'b0, g);
        grant_phase(4, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        repeat (5) step();
        check("pending_om_writes", wr_q.size(), 0);
        check("pending_in_progress_edges", nip_q.size(), 0);
        check("pending_hold_edges", hold_q.size(), 0);
        check("pending_timeout_edges", tmo_q.size(), 0);
        check("pending_game_started", start_q.size(), 0);
        check("pending_reset_snapshots", snap_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
